ring_token_scheduler: RTL and testbench

Round-robin resource scheduler built around a one-hot token ring, the control-side companion to the team's ring shift registers. N requesters share one resource. A single token rotates one position per clock until it lands on an active requester, which is then granted exclusive use until it releases. An optional hold-time limit preempts owners that hold the resource too long.

---
 rtl/ring_token_scheduler.sv | 142 ++++++++++++++
 tb/tb_ring_token_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_token_scheduler.sv
// Round-robin scheduler: a one-hot token rotates to the next active requester, which keeps the grant until it releases.
// Optional macro RING_SCHED_TIMEOUT_EN enables a MAX_HOLD-cycle hold limit with a one-cycle preempt pulse.
module ring_token_scheduler #(
   parameter int N        = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         token,
   output logic                 busy,
   output logic                 preempt
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t         state_r, state_nxt_s;
   logic [N-1:0]   token_r, token_nxt_s, token_rot_s;
   logic           hit_s, any_s, timeout_s;
   logic [IW-1:0]  grant_id_s;

   assign token_rot_s = {token_r[N-2:0], token_r[N-1]};
   assign hit_s       = |(req & token_r);
   assign any_s       = |req;

`ifdef RING_SCHED_TIMEOUT_EN
   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   logic [HW-1:0] hold_cnt_r, hold_nxt_s;
   logic          preempt_r, preempt_nxt_s;

   assign timeout_s = (hold_cnt_r == HOLD_LAST);
   assign preempt   = preempt_r;

   // Hold counter restarts on every entry to GRANT; a forced release flags preempt for one cycle.
   always_comb begin
      hold_nxt_s    = {HW{1'b0}};
      preempt_nxt_s = 1'b0;
      if (state_nxt_s == GRANT && state_r == GRANT) begin
         hold_nxt_s = hold_cnt_r + {{(HW-1){1'b0}}, 1'b1};
      end else begin
         hold_nxt_s = {HW{1'b0}};
      end
      if (state_r == GRANT && hit_s && timeout_s) begin
         preempt_nxt_s = 1'b1;
      end else begin
         preempt_nxt_s = 1'b0;
      end
   end

   // Hold counter and preempt pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt_r <= {HW{1'b0}};
         preempt_r  <= 1'b0;
      end else begin
         hold_cnt_r <= hold_nxt_s;
         preempt_r  <= preempt_nxt_s;
      end
   end
`else
   assign timeout_s = 1'b0;
   assign preempt   = 1'b0;
`endif

   // Next-state and token movement; every release rotates so the search resumes after the old owner.
   always_comb begin
      state_nxt_s = state_r;
      token_nxt_s = token_r;
      case (state_r)
         IDLE: begin
            if (hit_s) begin
               state_nxt_s = GRANT;
            end else if (any_s) begin
               state_nxt_s = SCAN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SCAN: begin
            if (hit_s) begin
               state_nxt_s = GRANT;
            end else if (!any_s) begin
               state_nxt_s = IDLE;
            end else begin
               token_nxt_s = token_rot_s;
               state_nxt_s = SCAN;
            end
         end
         GRANT: begin
            if (!hit_s || timeout_s) begin
               token_nxt_s = token_rot_s;
               state_nxt_s = SCAN;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            token_nxt_s = {{(N-1){1'b0}}, 1'b1};
         end
      endcase
   end

   // State and token registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         token_r <= {{(N-1){1'b0}}, 1'b1};
      end else begin
         state_r <= state_nxt_s;
         token_r <= token_nxt_s;
      end
   end

   // Binary index of the token bit.
   always_comb begin
      grant_id_s = {IW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (token_r[i]) begin
            grant_id_s = i[IW-1:0];
         end else begin
            grant_id_s = grant_id_s;
         end
      end
   end

   assign grant    = (state_r == GRANT) ? token_r : {N{1'b0}};
   assign grant_id = grant_id_s;
   assign token    = token_r;
   assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_ring_token_scheduler.sv
// Self-checking bench for ring_token_scheduler: directed scenarios plus random requests against an index-based model.
module tb_ring_token_scheduler;

   localparam int N        = 5;
   localparam int MAX_HOLD = 8;
   localparam int IW       = $clog2(N);

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic [IW-1:0] grant_id;
   logic [N-1:0]  token;
   logic          busy;
   logic          preempt;

   int errors = 0;
   int checks = 0;

   // model: token position, current owner (-1 = none), searching flag, hold length, preempt pulse
   int m_pos;
   int m_owner;
   bit m_search;
   int m_hold;
   bit m_pre;

   ring_token_scheduler #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .grant(grant),
      .grant_id(grant_id), .token(token), .busy(busy), .preempt(preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef RING_SCHED_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_owner = -1; m_search = 1'b0; m_hold = 0; m_pre = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      m_pre = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_pos = (m_pos + 1) % N; m_owner = -1; m_search = 1'b1;
         end else if (TIMEOUT && m_hold == MAX_HOLD - 1) begin
            m_pos = (m_pos + 1) % N; m_owner = -1; m_search = 1'b1; m_pre = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (r[m_pos]) begin
         m_owner = m_pos; m_hold = 0; m_search = 1'b0;
      end else if (r != '0) begin
         if (m_search) m_pos = (m_pos + 1) % N;
         m_search = 1'b1;
      end else begin
         m_search = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] e_tok;
      logic [N-1:0] e_gnt;
      e_tok = '0; e_tok[m_pos] = 1'b1;
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      chk({tag, ".token"},    32'(token),    32'(e_tok));
      chk({tag, ".grant"},    32'(grant),    32'(e_gnt));
      chk({tag, ".grant_id"}, 32'(grant_id), 32'(m_pos));
      chk({tag, ".busy"},     32'(busy),     32'((m_owner >= 0) || m_search));
      chk({tag, ".preempt"},  32'(preempt),  32'(m_pre));
   endtask

   // apply req before the edge, advance model on the edge, sample 1 time unit later
   task automatic cycle(input logic [N-1:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      check_model(tag);
      @(negedge clk);
   endtask

   // asynchronous reset pulse between edges, checked before any clock edge
   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_model(tag);
      chk({tag, ".grant0"}, 32'(grant), 32'd0);
      chk({tag, ".token1"}, 32'(token), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin : main
      logic [N-1:0] order_exp [6];
      logic [N-1:0] last_g;
      int n_rr;
      int n_on;
      int k;
      bit hit;

      req = '0;
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);

      // reset values, immediately on assertion
      async_reset("reset");
      chk("reset.busy0", 32'(busy), 32'd0);

      // single request at distance 2: grant after edge 4
      for (int i = 1; i <= 4; i++) cycle(5'b00100, "single.acq");
      chk("single.grant_e4", 32'(grant), 32'(5'b00100));
      for (int i = 0; i < 3; i++) cycle(5'b00100, "single.hold");
      cycle(5'b00000, "single.rel");
      chk("single.rel_token", 32'(token), 32'(5'b01000));
      chk("single.rel_grant", 32'(grant), 32'd0);
      cycle(5'b00000, "single.idle");
      chk("single.idle_busy", 32'(busy), 32'd0);

      // round-robin order from reset, owner drops for one cycle after its grant cycle
      async_reset("rr.reset");
      order_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      n_rr = 0;
      last_g = '0;
      for (int i = 0; i < 40 && n_rr < 6; i++) begin
         cycle((grant != '0) ? (5'b11111 & ~grant) : 5'b11111, "rr");
         if (grant != '0 && grant != last_g) begin
            chk($sformatf("rr.order%0d", n_rr), 32'(grant), 32'(order_exp[n_rr]));
            n_rr++;
         end
         last_g = grant;
      end
      chk("rr.count", 32'(n_rr), 32'd6);

      // wrap-around: token at bit 4 in SCAN, request on bit 0
      async_reset("wrap.reset");
      for (int i = 0; i < 5; i++) cycle(5'b10000, "wrap.seek");
      chk("wrap.tok4", 32'(token), 32'(5'b10000));
      cycle(5'b00001, "wrap.rot");
      chk("wrap.tok0", 32'(token), 32'(5'b00001));
      cycle(5'b00001, "wrap.grant");
      chk("wrap.grant0", 32'(grant), 32'(5'b00001));

      // hold limit: constant request at the token position
      async_reset("to.reset");
      cycle(5'b00001, "to.acq");
      n_on = 1;
      for (int i = 0; i < 109; i++) begin
         cycle(5'b00001, "to.hold");
         if (grant == 5'b00001) n_on++;
         else break;
      end
      if (TIMEOUT) begin
         chk("to.len", 32'(n_on), 32'(MAX_HOLD));
         chk("to.preempt", 32'(preempt), 32'd1);
         chk("to.token", 32'(token), 32'(5'b00010));
         k = 0;
         hit = 1'b0;
         for (int i = 1; i <= 10 && !hit; i++) begin
            cycle(5'b00001, "to.regrant");
            if (grant == 5'b00001) begin k = i; hit = 1'b1; end
         end
         chk("to.regrant_edges", 32'(k), 32'd5);
      end else begin
         chk("to.persist", 32'(n_on), 32'd110);
      end

      // reset during a grant to requester 3
      async_reset("mid.reset0");
      for (int i = 0; i < 5; i++) cycle(5'b01000, "mid.acq");
      chk("mid.grant3", 32'(grant), 32'(5'b01000));
      async_reset("mid.reset");
      cycle(5'b00001, "mid.after");
      chk("mid.after_grant", 32'(grant), 32'(5'b00001));

      // random traffic, sparse and dense, with occasional asynchronous resets
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] r;
         r = N'($urandom);
         if ($urandom_range(0, 3) == 0) r = '0;
         else if ($urandom_range(0, 2) == 0) r = r & N'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
         cycle(r, "rand");
         if ($urandom_range(0, 99) == 0) async_reset("rand.reset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
